// File: rtl/dma_request_agent_if.sv
// dma_request_agent_if
//   Groups the load port, the DREQ/DACK/EOP_N handshake and the status
//   outputs of the DMA request agent.
//
//   Handshake: a transfer beat on channel n happens in any cycle where
//   DREQ[n] (driven by the agent) and DACK[n] (driven by the controller)
//   are both 1.  DACK may be a combinational function of DREQ.
//   loadValid is a one-cycle strobe with no ready: the agent simply ignores
//   loads it cannot accept.
//
//   master : the DMA controller / environment side (drives loads, DACK, EOP_N)
//   slave  : the request agent (drives DREQ, status and debug state)
//
//   stateDbg packs the 2-bit FSM state of each channel, channel 0 in [1:0].
interface dma_request_agent_if;
  logic       loadValid;
  logic [1:0] loadChannel;
  logic [7:0] loadCount;
  logic       loadMode;
  logic [3:0] DACK;
  logic       EOP_N;
  logic [3:0] DREQ;
  logic [3:0] channelDone;
  logic [3:0] busy;
  logic       protocolError;
  logic [7:0] stateDbg;

  modport master (
    output loadValid, loadChannel, loadCount, loadMode, DACK, EOP_N,
    input  DREQ, channelDone, busy, protocolError, stateDbg
  );

  modport slave (
    input  loadValid, loadChannel, loadCount, loadMode, DACK, EOP_N,
    output DREQ, channelDone, busy, protocolError, stateDbg
  );
endinterface

// File: rtl/dma_request_agent.sv
// dma_request_agent
//   Four-channel peripheral-side DREQ/DACK request agent.  Each channel is
//   programmed with a transfer count and a mode (0 = single, 1 = demand),
//   raises DREQ while transfers remain, counts granted beats, honours EOP_N
//   on a beat and pulses channelDone on completion.  Protocol violations
//   (multi-hot DACK, or DACK without DREQ) set a sticky protocolError.
//
// Ports
//   CLK    : clock, all state on rising edge
//   RESET  : asynchronous active-high reset
//   bus    : dma_request_agent_if.slave
//            in : loadValid, loadChannel, loadCount, loadMode, DACK, EOP_N
//            out: DREQ, channelDone, busy, protocolError, stateDbg
module dma_request_agent (
  input  logic                      CLK,
  input  logic                      RESET,
  dma_request_agent_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } chState_t;

  chState_t   state [4];
  logic [7:0] pendingCount [4];
  logic       mode [4];

  logic [3:0] dreqR;
  logic [3:0] busyR;
  logic [3:0] doneR;
  logic       errR;

  logic       multiHot;
  logic       strayAck;
  logic [3:0] beat;

  // x & (x-1) clears the lowest set bit; non-zero means two or more bits set.
  always_comb begin
    multiHot = (bus.DACK & (bus.DACK - 4'd1)) != 4'd0;
    strayAck = |(bus.DACK & ~dreqR);
    // A multi-hot cycle is a violation as a whole: no channel counts a beat.
    beat     = multiHot ? 4'd0 : (bus.DACK & dreqR);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int n = 0; n < 4; n++) begin
        state[n]        <= IDLE;
        pendingCount[n] <= 8'd0;
        mode[n]         <= 1'b0;
      end
      dreqR <= 4'd0;
      busyR <= 4'd0;
      doneR <= 4'd0;
      errR  <= 1'b0;
    end else begin
      errR <= errR | multiHot | strayAck;
      for (int n = 0; n < 4; n++) begin
        doneR[n] <= 1'b0;
        case (state[n])
          IDLE: begin
            if (bus.loadValid && (bus.loadChannel == 2'(n)) && (bus.loadCount != 8'd0)) begin
              pendingCount[n] <= bus.loadCount;
              mode[n]         <= bus.loadMode;
              state[n]        <= REQ;
              dreqR[n]        <= 1'b1;
              busyR[n]        <= 1'b1;
            end
          end
          REQ: begin
            if (beat[n]) begin
              if ((pendingCount[n] == 8'd1) || !bus.EOP_N) begin
                pendingCount[n] <= 8'd0;
                state[n]        <= IDLE;
                dreqR[n]        <= 1'b0;
                busyR[n]        <= 1'b0;
                doneR[n]        <= 1'b1;
              end else begin
                pendingCount[n] <= pendingCount[n] - 8'd1;
                if (!mode[n]) begin
                  state[n] <= GAP;
                  dreqR[n] <= 1'b0;
                end
              end
            end
          end
          GAP: begin
            state[n] <= REQ;
            dreqR[n] <= 1'b1;
          end
          default: begin
            state[n] <= IDLE;
            dreqR[n] <= 1'b0;
            busyR[n] <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.DREQ          = dreqR;
  assign bus.busy          = busyR;
  assign bus.channelDone   = doneR;
  assign bus.protocolError = errR;
  assign bus.stateDbg      = {state[3], state[2], state[1], state[0]};

endmodule

// File: tb/tb_dma_request_agent.sv
// tb_dma_request_agent
//   Directed scenarios plus a randomized run for dma_request_agent.  The
//   reference model tracks, per channel, the number of transfers still owed,
//   the mode and whether a single-mode pause is due; DREQ/busy/channelDone/
//   protocolError expectations follow from those.
module tb_dma_request_agent;

  logic CLK;
  logic RESET;

  dma_request_agent_if bus ();

  dma_request_agent dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;

  // reference model
  int         remaining [4];
  logic       modeM [4];
  logic       pauseDue [4];
  logic [3:0] expDone;
  logic       expErr;

  function automatic logic [3:0] modelDreq();
    logic [3:0] r;
    for (int n = 0; n < 4; n++) r[n] = (remaining[n] != 0) && !pauseDue[n];
    return r;
  endfunction

  function automatic logic [3:0] modelBusy();
    logic [3:0] r;
    for (int n = 0; n < 4; n++) r[n] = (remaining[n] != 0);
    return r;
  endfunction

  // lowest-index request wins
  function automatic logic [3:0] prio(input logic [3:0] r);
    return r & (~r + 4'd1);
  endfunction

  task automatic modelReset();
    for (int n = 0; n < 4; n++) begin
      remaining[n] = 0;
      modeM[n]     = 1'b0;
      pauseDue[n]  = 1'b0;
    end
    expDone = 4'd0;
    expErr  = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic modelAdvance();
    logic [3:0] dreqNow;
    logic       multi;
    dreqNow = modelDreq();
    multi   = $countones(bus.DACK) > 1;
    if (multi || ((bus.DACK & ~dreqNow) != 4'd0)) expErr = 1'b1;
    expDone = 4'd0;
    for (int n = 0; n < 4; n++) begin
      if (remaining[n] == 0) begin
        if (bus.loadValid && (int'(bus.loadChannel) == n) && (bus.loadCount != 0)) begin
          remaining[n] = int'(bus.loadCount);
          modeM[n]     = bus.loadMode;
          pauseDue[n]  = 1'b0;
        end
      end else if (pauseDue[n]) begin
        pauseDue[n] = 1'b0;
      end else if (bus.DACK[n] && !multi) begin
        if ((remaining[n] == 1) || !bus.EOP_N) begin
          remaining[n] = 0;
          expDone[n]   = 1'b1;
        end else begin
          remaining[n] = remaining[n] - 1;
          pauseDue[n]  = !modeM[n];
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    chk({tag, ".dreq"}, bus.DREQ, modelDreq());
    chk({tag, ".busy"}, bus.busy, modelBusy());
    chk({tag, ".done"}, bus.channelDone, expDone);
    chk({tag, ".err"},  {3'b000, bus.protocolError}, {3'b000, expErr});
  endtask

  // Apply inputs, clock once, then compare one time unit after the edge.
  task automatic step(input string tag, input logic lv, input logic [1:0] lc,
                      input logic [7:0] lcnt, input logic lm,
                      input logic [3:0] dack, input logic eopn);
    bus.loadValid   = lv;
    bus.loadChannel = lc;
    bus.loadCount   = lcnt;
    bus.loadMode    = lm;
    bus.DACK        = dack;
    bus.EOP_N       = eopn;
    modelAdvance();
    @(posedge CLK);
    #1;
    checkAll(tag);
  endtask

  task automatic idleStep(input string tag, input logic [3:0] dack);
    step(tag, 1'b0, 2'd0, 8'd0, 1'b0, dack, 1'b1);
  endtask

  task automatic doReset();
    RESET = 1'b1;
    modelReset();
    @(posedge CLK);
    #1;
    checkAll("reset");
    RESET = 1'b0;
  endtask

  initial begin : main
    int doneCycle [4];
    int doneCnt [4];
    logic [3:0] r;
    logic finished;

    RESET = 1'b1;
    bus.loadValid   = 1'b0;
    bus.loadChannel = 2'd0;
    bus.loadCount   = 8'd0;
    bus.loadMode    = 1'b0;
    bus.DACK        = 4'd0;
    bus.EOP_N       = 1'b1;
    modelReset();
    #1;
    checkAll("por");
    doReset();

    // single mode, ch0 count 3, DACK[0] follows DREQ[0]
    step("s_load", 1'b1, 2'd0, 8'd3, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 7; i++) idleStep("s_run", modelDreq() & 4'b0001);

    // demand mode, ch2 count 4, DACK[2] held while requested
    step("d_load", 1'b1, 2'd2, 8'd4, 1'b1, 4'd0, 1'b1);
    for (int i = 0; i < 6; i++) idleStep("d_run", modelDreq() & 4'b0100);

    // ch1 demand count 10, EOP_N low on the second beat
    step("e_load", 1'b1, 2'd1, 8'd10, 1'b1, 4'd0, 1'b1);
    step("e_b1", 1'b0, 2'd0, 8'd0, 1'b0, 4'b0010, 1'b1);
    step("e_b2", 1'b0, 2'd0, 8'd0, 1'b0, 4'b0010, 1'b0);
    idleStep("e_after", 4'd0);
    // reload count 1: one beat finishes it
    step("e_rel", 1'b1, 2'd1, 8'd1, 1'b0, 4'd0, 1'b1);
    idleStep("e_rel_b", 4'b0010);
    idleStep("e_rel_d", 4'd0);

    // zero-count load is ignored
    step("z_load", 1'b1, 2'd3, 8'd0, 1'b0, 4'd0, 1'b1);
    idleStep("z_after", 4'd0);

    // all four channels count 2 single, fixed-priority DACK
    for (int n = 0; n < 4; n++) begin
      doneCycle[n] = -1;
      doneCnt[n]   = 0;
    end
    for (int n = 0; n < 4; n++) begin
      step("a_load", 1'b1, 2'(n), 8'd2, 1'b0, prio(modelDreq()), 1'b1);
      for (int k = 0; k < 4; k++) if (bus.channelDone[k]) begin doneCnt[k]++; doneCycle[k] = n; end
    end
    finished = 1'b0;
    for (int c = 4; c < 60 && !finished; c++) begin
      idleStep("a_run", prio(modelDreq()));
      for (int k = 0; k < 4; k++) if (bus.channelDone[k]) begin doneCnt[k]++; doneCycle[k] = c; end
      if (modelBusy() == 4'd0) finished = 1'b1;
    end
    chk("a_timeout", {3'b000, finished}, 4'd1);
    for (int n = 0; n < 4; n++) chk("a_donecnt", 4'(doneCnt[n]), 4'd1);
    chk("a_order", {3'b000, (doneCycle[0] < doneCycle[1]) && (doneCycle[1] < doneCycle[2])
                            && (doneCycle[2] < doneCycle[3])}, 4'd1);

    // randomized traffic, legal DACK only
    for (int i = 0; i < 400; i++) begin
      r = 4'($urandom_range(0, 15));
      step("rnd", $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
           8'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
           prio(modelDreq() & r), $urandom_range(0, 9) != 0);
    end
    for (int i = 0; i < 20; i++) idleStep("drain", prio(modelDreq()));
    doReset();

    // protocol errors: multi-hot DACK (no beat), then DACK without DREQ
    step("p_l0", 1'b1, 2'd0, 8'd2, 1'b1, 4'd0, 1'b1);
    step("p_l1", 1'b1, 2'd1, 8'd2, 1'b1, 4'd0, 1'b1);
    step("p_multi", 1'b0, 2'd0, 8'd0, 1'b0, 4'b0011, 1'b1);
    step("p_stray", 1'b0, 2'd0, 8'd0, 1'b0, 4'b1000, 1'b1);
    for (int i = 0; i < 6; i++) idleStep("p_run", prio(modelDreq()));
    doReset();

    // reset mid-transfer on ch0 after two beats
    step("r_load", 1'b1, 2'd0, 8'd5, 1'b0, 4'd0, 1'b1);
    idleStep("r_b1", 4'b0001);
    idleStep("r_gap", 4'd0);
    idleStep("r_b2", 4'b0001);
    #3;
    RESET = 1'b1;
    modelReset();
    #1;
    checkAll("r_async");
    @(posedge CLK);
    #1;
    checkAll("r_hold");
    RESET = 1'b0;
    step("r_reload", 1'b1, 2'd0, 8'd1, 1'b0, 4'd0, 1'b1);
    idleStep("r_beat", 4'b0001);
    idleStep("r_end", 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
